// File: rtl/oven_cook_sequencer.sv
// Oven cook sequencer: time entry, preheat, timed cook, pause on door,
// end-of-cook alarm and preheat fault. Cook time is counted down from the
// 1 Hz strobe, so the sequence does not depend on any wall-clock wrap.
`timescale 1ns/1ps
module oven_cook_sequencer #(
  parameter int MAX_COOK        = 3599,
  parameter int PREHEAT_TIMEOUT = 900,
  parameter int ALARM_SECS      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic [12:0] time_in,
  input  logic        time_load,
  input  logic        start,
  input  logic        cancel,
  input  logic        door_open,
  input  logic        temp_reached,
  output logic        heater_on,
  output logic        timeinputdone,
  output logic        preheated,
  output logic        cooking,
  output logic [12:0] remaining,
  output logic [3:0]  progress,
  output logic        done,
  output logic        buzzer,
  output logic        error
);

  // One shared second counter serves both PREHEAT and ALARM, sized for the longer.
  localparam int CNT_MAX = (PREHEAT_TIMEOUT > ALARM_SECS) ? PREHEAT_TIMEOUT : ALARM_SECS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PREHEAT_LAST = CNT_W'(PREHEAT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST   = CNT_W'(ALARM_SECS - 1);
  localparam logic [12:0]      MAX_TIME     = 13'(MAX_COOK);

  typedef enum logic [2:0] {
    IDLE, LOADED, PREHEAT, COOK, PAUSE, ALARM, DONE, FAULT
  } state_t;

  state_t           state, state_d;
  logic [12:0]      cook_time, cook_time_d, remaining_d;
  logic [CNT_W-1:0] count, count_d;
  logic [3:0]       progress_d;
  logic             heater_d, tid_d, preheated_d, cooking_d, done_d, buzzer_d, error_d;
  logic             door_q;
  logic             go_idle;
  logic [16:0]      elapsed_x10;

  // State and all registered outputs; door_q remembers the door for edge detection in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cook_time     <= '0;
      remaining     <= '0;
      count         <= '0;
      progress      <= '0;
      heater_on     <= 1'b0;
      timeinputdone <= 1'b0;
      preheated     <= 1'b0;
      cooking       <= 1'b0;
      done          <= 1'b0;
      buzzer        <= 1'b0;
      error         <= 1'b0;
      door_q        <= 1'b0;
    end else begin
      state         <= state_d;
      cook_time     <= cook_time_d;
      remaining     <= remaining_d;
      count         <= count_d;
      progress      <= progress_d;
      heater_on     <= heater_d;
      timeinputdone <= tid_d;
      preheated     <= preheated_d;
      cooking       <= cooking_d;
      done          <= done_d;
      buzzer        <= buzzer_d;
      error         <= error_d;
      door_q        <= door_open;
    end
  end

  // Next-state and next-output logic; cancel beats door, door beats start/tick/temp.
  always_comb begin
    state_d     = state;
    cook_time_d = cook_time;
    remaining_d = remaining;
    count_d     = count;
    heater_d    = heater_on;
    tid_d       = timeinputdone;
    preheated_d = preheated;
    cooking_d   = cooking;
    done_d      = done;
    buzzer_d    = buzzer;
    error_d     = error;
    go_idle     = cancel;
    progress_d  = '0;
    elapsed_x10 = 17'(cook_time - remaining) * 17'd10;

    if (!cancel) begin
      case (state)
        IDLE, LOADED: begin
          if (time_load) begin
            if (time_in != 13'd0 && time_in <= MAX_TIME) begin
              cook_time_d = time_in;
              remaining_d = time_in;
              tid_d       = 1'b1;
              error_d     = 1'b0;
              state_d     = LOADED;
            end else begin
              error_d = 1'b1;
            end
          end
          if (state == LOADED && !door_open && start) begin
            state_d  = PREHEAT;
            heater_d = 1'b1;
            count_d  = '0;
          end
        end
        PREHEAT: begin
          if (!door_open) begin
            if (temp_reached) begin
              state_d     = COOK;
              preheated_d = 1'b1;
              cooking_d   = 1'b1;
            end else if (tick_1hz) begin
              if (count == PREHEAT_LAST) begin
                state_d  = FAULT;
                heater_d = 1'b0;
                error_d  = 1'b1;
              end else begin
                count_d = count + 1'b1;
              end
            end
          end
        end
        COOK: begin
          if (door_open) begin
            state_d   = PAUSE;
            heater_d  = 1'b0;
            cooking_d = 1'b0;
          end else if (tick_1hz) begin
            if (remaining <= 13'd1) begin
              remaining_d = '0;
              state_d     = ALARM;
              heater_d    = 1'b0;
              cooking_d   = 1'b0;
              done_d      = 1'b1;
              buzzer_d    = 1'b1;
              count_d     = '0;
            end else begin
              remaining_d = remaining - 13'd1;
            end
          end
        end
        PAUSE: begin
          if (!door_open && start) begin
            state_d   = COOK;
            heater_d  = 1'b1;
            cooking_d = 1'b1;
          end
        end
        ALARM: begin
          if (door_open) begin
            state_d  = DONE;
            buzzer_d = 1'b0;
          end else if (tick_1hz) begin
            if (count == ALARM_LAST) begin
              state_d  = DONE;
              buzzer_d = 1'b0;
            end else begin
              count_d = count + 1'b1;
            end
          end
        end
        DONE: begin
          if (door_open && !door_q) go_idle = 1'b1;
        end
        FAULT: begin
        end
        default: go_idle = 1'b1;
      endcase
    end

    if (go_idle) begin
      state_d     = IDLE;
      cook_time_d = '0;
      remaining_d = '0;
      count_d     = '0;
      heater_d    = 1'b0;
      tid_d       = 1'b0;
      preheated_d = 1'b0;
      cooking_d   = 1'b0;
      done_d      = 1'b0;
      buzzer_d    = 1'b0;
      error_d     = 1'b0;
    end

    if (state_d != IDLE && cook_time != 13'd0)
      progress_d = 4'(elapsed_x10 / {4'd0, cook_time});
  end

endmodule

// File: tb/tb_oven_cook_sequencer.sv
// Directed bench for oven_cook_sequencer: each step pushes its expected
// output snapshot to a scoreboard queue, drives the strobes, then pops and
// compares against the DUT two clock edges later.
`timescale 1ns/1ps
module tb_oven_cook_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        tick_1hz = 1'b0, time_load = 1'b0, start = 1'b0, cancel = 1'b0;
  logic        door_open = 1'b0, temp_reached = 1'b0;
  logic [12:0] time_in = '0;
  logic        heater_on, timeinputdone, preheated, cooking, done, buzzer, error;
  logic [12:0] remaining;
  logic [3:0]  progress;

  typedef struct {
    string       tag;
    logic        heater, tid, pre, cook;
    logic [12:0] rem;
    logic [3:0]  prog;
    logic        dn, buz, err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  oven_cook_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .time_in(time_in),
    .time_load(time_load), .start(start), .cancel(cancel), .door_open(door_open),
    .temp_reached(temp_reached), .heater_on(heater_on), .timeinputdone(timeinputdone),
    .preheated(preheated), .cooking(cooking), .remaining(remaining), .progress(progress),
    .done(done), .buzzer(buzzer), .error(error)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input string tag, input logic h, t, p, c,
                              input logic [12:0] r, input logic [3:0] g,
                              input logic d, b, e);
    exp_t x;
    x.tag = tag; x.heater = h; x.tid = t; x.pre = p; x.cook = c;
    x.rem = r; x.prog = g; x.dn = d; x.buz = b; x.err = e;
    return x;
  endfunction

  // One field comparison against the scoreboard entry.
  task automatic chk(input string tag, input string field,
                     input logic [12:0] obs, input logic [12:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s.%s observed %0d expected %0d", tag, field, obs, expv);
    end
  endtask

  // Pop the oldest expectation and compare every output.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard observed empty expected entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "heater_on",     13'(heater_on),     13'(e.heater));
      chk(e.tag, "timeinputdone", 13'(timeinputdone), 13'(e.tid));
      chk(e.tag, "preheated",     13'(preheated),     13'(e.pre));
      chk(e.tag, "cooking",       13'(cooking),       13'(e.cook));
      chk(e.tag, "remaining",     remaining,          e.rem);
      chk(e.tag, "progress",      13'(progress),      13'(e.prog));
      chk(e.tag, "done",          13'(done),          13'(e.dn));
      chk(e.tag, "buzzer",        13'(buzzer),        13'(e.buz));
      chk(e.tag, "error",         13'(error),         13'(e.err));
    end
  endtask

  // Drive one-cycle strobes, then let one more edge pass so progress settles.
  task automatic applyStimulus(input logic tk, tl, st, ca, input logic [12:0] tin);
    @(negedge clk);
    tick_1hz = tk; time_load = tl; start = st; cancel = ca; time_in = tin;
    @(negedge clk);
    tick_1hz = 1'b0; time_load = 1'b0; start = 1'b0; cancel = 1'b0;
    @(negedge clk);
  endtask

  // Push expectation, apply stimulus, compare.
  task automatic step(input logic tk, tl, st, ca, input logic [12:0] tin, input exp_t e);
    sb.push_back(e);
    applyStimulus(tk, tl, st, ca, tin);
    checkOutput();
  endtask

  // Directed test sequence.
  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk("reset", 0,0,0,0, 0,0, 0,0,0));
    checkOutput();

    // Entry validation
    step(0,1,0,0, 13'd0,    mk("load0",    0,0,0,0, 0,0, 0,0,1));
    step(0,1,0,0, 13'd3600, mk("load3600", 0,0,0,0, 0,0, 0,0,1));
    step(1,0,0,0, 13'd0,    mk("idle_tick",0,0,0,0, 0,0, 0,0,1));
    step(0,1,0,0, 13'd5,    mk("load5",    0,1,0,0, 5,0, 0,0,0));

    // Full 5 s cook
    step(0,0,1,0, 13'd0, mk("start5", 1,1,0,0, 5,0, 0,0,0));
    for (int i = 0; i < 3; i++)
      step(1,0,0,0, 13'd0, mk("preheat5_tick", 1,1,0,0, 5,0, 0,0,0));
    temp_reached = 1'b1;
    step(0,0,0,0, 13'd0, mk("temp5", 1,1,1,1, 5,0, 0,0,0));
    temp_reached = 1'b0;
    for (int i = 1; i <= 4; i++)
      step(1,0,0,0, 13'd0, mk("cook5_tick", 1,1,1,1, 13'(5 - i), 4'(2 * i), 0,0,0));
    step(1,0,0,0, 13'd0, mk("cook5_end", 0,1,1,0, 0,10, 1,1,0));
    for (int i = 1; i <= 9; i++)
      step(1,0,0,0, 13'd0, mk("alarm_tick", 0,1,1,0, 0,10, 1,1,0));
    step(1,0,0,0, 13'd0, mk("alarm_end", 0,1,1,0, 0,10, 1,0,0));
    step(0,0,1,0, 13'd0, mk("done_start", 0,1,1,0, 0,10, 1,0,0));
    door_open = 1'b1;
    step(0,0,0,0, 13'd0, mk("done_door", 0,0,0,0, 0,0, 0,0,0));
    door_open = 1'b0;

    // Pause and resume on 10 s cook
    step(0,1,0,0, 13'd10, mk("load10",  0,1,0,0, 10,0, 0,0,0));
    step(0,0,1,0, 13'd0,  mk("start10", 1,1,0,0, 10,0, 0,0,0));
    temp_reached = 1'b1;
    step(0,0,0,0, 13'd0,  mk("temp10",  1,1,1,1, 10,0, 0,0,0));
    temp_reached = 1'b0;
    for (int i = 1; i <= 4; i++)
      step(1,0,0,0, 13'd0, mk("cook10_tick", 1,1,1,1, 13'(10 - i), 4'(i), 0,0,0));
    door_open = 1'b1;
    step(1,0,0,0, 13'd0, mk("pause_entry", 0,1,1,0, 6,4, 0,0,0));
    for (int i = 0; i < 3; i++)
      step(1,0,0,0, 13'd0, mk("pause_tick", 0,1,1,0, 6,4, 0,0,0));
    door_open = 1'b0;
    step(0,0,1,0, 13'd0, mk("resume", 1,1,1,1, 6,4, 0,0,0));
    for (int i = 1; i <= 5; i++)
      step(1,0,0,0, 13'd0, mk("resume_tick", 1,1,1,1, 13'(6 - i), 4'(4 + i), 0,0,0));
    step(1,0,0,0, 13'd0, mk("cook10_end", 0,1,1,0, 0,10, 1,1,0));
    door_open = 1'b1;
    step(0,0,0,1, 13'd0, mk("alarm_cancel_door", 0,0,0,0, 0,0, 0,0,0));
    door_open = 1'b0;

    // Preheat timeout, with door-open seconds not counted
    step(0,1,0,0, 13'd20, mk("load20",  0,1,0,0, 20,0, 0,0,0));
    step(0,0,1,0, 13'd0,  mk("start20", 1,1,0,0, 20,0, 0,0,0));
    door_open = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1,0,0,0, 13'd0);
    step(0,0,0,0, 13'd0, mk("preheat_door", 1,1,0,0, 20,0, 0,0,0));
    door_open = 1'b0;
    for (int i = 0; i < 899; i++) applyStimulus(1,0,0,0, 13'd0);
    step(0,0,0,0, 13'd0, mk("preheat_899", 1,1,0,0, 20,0, 0,0,0));
    step(1,0,0,0, 13'd0, mk("fault",       0,1,0,0, 20,0, 0,0,1));
    step(0,0,1,0, 13'd0, mk("fault_start", 0,1,0,0, 20,0, 0,0,1));
    step(0,0,0,1, 13'd0, mk("fault_cancel",0,0,0,0, 0,0, 0,0,0));

    // Asynchronous reset in the middle of cooking
    step(0,1,0,0, 13'd37, mk("load37",  0,1,0,0, 37,0, 0,0,0));
    step(0,0,1,0, 13'd0,  mk("start37", 1,1,0,0, 37,0, 0,0,0));
    temp_reached = 1'b1;
    step(0,0,0,0, 13'd0,  mk("cook37",  1,1,1,1, 37,0, 0,0,0));
    temp_reached = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(mk("async_reset", 0,0,0,0, 0,0, 0,0,0));
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    step(1,0,1,0, 13'd0, mk("post_reset", 0,0,0,0, 0,0, 0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
